// File: rtl/fpnew_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_sched_pkg
// Purpose  : Shared types for the FPU request scheduler. These are the FPU
//            request/response bundles, the scheduler state encoding and the
//            tag-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package fpnew_sched_pkg;

  // Datapath width of the attached FPU (its Features.Width).
  localparam int unsigned FpuWidth    = 64;
  localparam int unsigned NumOperands = 3;

  typedef struct packed {
    logic nv;  // invalid
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

  typedef struct packed {
    logic [NumOperands-1:0][FpuWidth-1:0] operands;
    logic [2:0]                           rnd_mode;
    logic [3:0]                           op;
    logic                                 op_mod;
    logic [2:0]                           src_fmt;
    logic [2:0]                           dst_fmt;
    logic [1:0]                           int_fmt;
    logic                                 vectorial_op;
  } fpu_req_t;

  typedef struct packed {
    logic [FpuWidth-1:0] result;
    status_t             status;
  } fpu_rsp_t;

  typedef enum logic [1:0] {
    SCHED_RUN   = 2'd0,
    SCHED_DRAIN = 2'd1,
    SCHED_FLUSH = 2'd2
  } sched_state_e;

  // Tag / index width: at least one bit, even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_sched_rr_pick
// Purpose  : Combinational rotate-priority picker. It selects the first
//            eligible index at or after ptr, wrapping from NumReq-1 to 0.
// Ports    : eligible - request vector
//            ptr      - round-robin start index
//            grant    - one-hot grant (zero when nothing is eligible)
//            idx      - binary index of the grant
//            any      - at least one request is eligible
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_sched_rr_pick
  import fpnew_sched_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] eligible,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  logic [NumReq-1:0] hi_mask;
  logic [NumReq-1:0] masked;
  logic [NumReq-1:0] search;

  // Requests at or above ptr take priority. If there are none, the search
  // wraps around to the lowest eligible index.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    masked = eligible & hi_mask;
    search = (|masked) ? masked : eligible;
    any    = |eligible;
    idx    = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (search[i]) begin
        idx = IdxW'(i);
      end
    end
    grant = any ? (NumReq'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/fpnew_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_req_scheduler
// Purpose  : Shares one FPU among NumReq requesters. It issues operations
//            round-robin, with the requester index carried as the FPU tag.
//            Results go back to their owner through a one-entry response
//            register. The block caps the number of in-flight ops and
//            supports drain and flush.
// Ports    : clk_i/rst_i              - clock, synchronous active-high reset
//            req_valid_i/req_ready_o  - per-requester issue handshake
//            req_i                    - per-requester operation
//            rsp_valid_o/rsp_ready_i  - per-requester result handshake
//            rsp_o                    - shared result bus
//            fpu_*                    - FPU input, output and flush ports
//            drain_i/flush_i          - quiesce / abort controls
//            drained_o/busy_o         - status
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_req_scheduler
  import fpnew_sched_pkg::*;
#(
  parameter  int unsigned NumReq         = 4,
  parameter  int unsigned Width          = FpuWidth,
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned IdxW           = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  input  fpu_req_t          req_i [NumReq],
  output logic [NumReq-1:0] rsp_valid_o,
  input  logic [NumReq-1:0] rsp_ready_i,
  output fpu_rsp_t          rsp_o,
  output fpu_req_t          fpu_req_o,
  output logic              fpu_in_valid_o,
  input  logic              fpu_in_ready_i,
  output logic [IdxW-1:0]   fpu_tag_o,
  output logic              fpu_flush_o,
  input  fpu_rsp_t          fpu_rsp_i,
  input  logic [IdxW-1:0]   fpu_tag_i,
  input  logic              fpu_out_valid_i,
  output logic              fpu_out_ready_o,
  input  logic              drain_i,
  input  logic              flush_i,
  output logic              drained_o,
  output logic              busy_o
);

  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  sched_state_e      state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              lock_q;
  logic [IdxW-1:0]   lock_idx_q;
  logic              full_q;
  logic [IdxW-1:0]   tag_q;
  fpu_rsp_t          rsp_q;

  logic [NumReq-1:0] pick_grant;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              use_lock;
  logic [IdxW-1:0]   win_idx;
  logic [NumReq-1:0] win_onehot;
  logic              issue_ok;
  logic              in_hs;
  logic              out_hs;

  fpnew_sched_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .eligible (req_valid_i),
    .ptr      (ptr_q),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // A winner offered without a handshake stays locked. A lower-index
  // requester that raises valid cannot steal the grant mid-handshake.
  assign use_lock   = lock_q && req_valid_i[lock_idx_q];
  assign win_idx    = use_lock ? lock_idx_q : pick_idx;
  assign win_onehot = use_lock ? (NumReq'(1) << lock_idx_q) : pick_grant;

  assign issue_ok       = !rst_i && (state_q == SCHED_RUN) && (cnt_q != MaxCnt);
  assign fpu_in_valid_o = issue_ok && pick_any;
  assign fpu_req_o      = req_i[win_idx];
  assign fpu_tag_o      = win_idx;
  assign in_hs          = fpu_in_valid_o && fpu_in_ready_i;
  assign req_ready_o    = in_hs ? win_onehot : '0;

  // The entry can be refilled in the same cycle that its owner drains it.
  assign fpu_out_ready_o = !rst_i && (state_q != SCHED_FLUSH) &&
                           (!full_q || rsp_ready_i[tag_q]);
  assign out_hs          = fpu_out_valid_i && fpu_out_ready_o;
  assign rsp_valid_o     = full_q ? (NumReq'(1) << tag_q) : '0;
  assign rsp_o           = rsp_q;

  assign fpu_flush_o = (state_q == SCHED_FLUSH);
  assign drained_o   = (state_q == SCHED_DRAIN) && (cnt_q == '0) && !full_q;
  assign busy_o      = (cnt_q != '0) || full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SCHED_RUN;
    end else begin
      case (state_q)
        SCHED_RUN:   state_q <= flush_i ? SCHED_FLUSH : (drain_i ? SCHED_DRAIN : SCHED_RUN);
        SCHED_DRAIN: state_q <= flush_i ? SCHED_FLUSH : (drain_i ? SCHED_DRAIN : SCHED_RUN);
        SCHED_FLUSH: state_q <= drain_i ? SCHED_DRAIN : SCHED_RUN;
        default:     state_q <= SCHED_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (in_hs) begin
        ptr_q <= (win_idx == LastIdx) ? '0 : win_idx + IdxW'(1);
      end
      lock_q     <= fpu_in_valid_o && !fpu_in_ready_i;
      lock_idx_q <= win_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == SCHED_FLUSH)) begin
      cnt_q <= '0;
    end else if (in_hs && !out_hs) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (!in_hs && out_hs) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == SCHED_FLUSH)) begin
      full_q <= 1'b0;
      tag_q  <= '0;
      rsp_q  <= '0;
    end else if (out_hs) begin
      full_q <= 1'b1;
      tag_q  <= fpu_tag_i;
      rsp_q  <= fpu_rsp_i;
    end else if (full_q && rsp_ready_i[tag_q]) begin
      full_q <= 1'b0;
    end
  end

  // Protocol checks.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (Width == FpuWidth);
      assert (!(in_hs && !out_hs && (cnt_q == MaxCnt)));
      assert (!(out_hs && !in_hs && (cnt_q == '0)));
    end
  end

  if ((1 << IdxW) != NumReq) begin : g_tag_check
    always_ff @(posedge clk_i) begin
      if (!rst_i && fpu_out_valid_i) begin
        assert (int'(fpu_tag_i) < int'(NumReq));
      end
    end
  end

  for (genvar g = 0; g < int'(NumReq); g++) begin : g_req_stable
    logic     pend_q;
    fpu_req_t req_prev_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= req_valid_i[g] && !req_ready_o[g];
        if (pend_q && req_valid_i[g]) begin
          assert (req_i[g] == req_prev_q);
        end
      end
      req_prev_q <= req_i[g];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_req_scheduler
// Purpose  : Directed, self-checking bench for fpnew_req_scheduler. DUT "a"
//            uses MaxOutstanding=8 and DUT "b" uses MaxOutstanding=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_req_scheduler;
  import fpnew_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_req_t req [N];

  // DUT a
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  fpu_rsp_t     rsp, fpu_rsp;
  fpu_req_t     fpu_req;
  logic         fpu_in_valid, fpu_in_ready, fpu_flush, fpu_out_valid, fpu_out_ready;
  logic [IW-1:0] fpu_tag, fpu_tag_in;
  logic         drain, flush, drained, busy;

  // DUT b
  logic [N-1:0] b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  fpu_rsp_t     b_rsp, b_fpu_rsp;
  fpu_req_t     b_fpu_req;
  logic         b_in_valid, b_in_ready, b_flush_o, b_out_valid, b_out_ready;
  logic [IW-1:0] b_tag, b_tag_in;
  logic         b_drain, b_flush, b_drained, b_busy;

  fpnew_req_scheduler #(.NumReq(N), .Width(64), .MaxOutstanding(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp), .fpu_req_o(fpu_req),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_tag_o(fpu_tag),
    .fpu_flush_o(fpu_flush), .fpu_rsp_i(fpu_rsp), .fpu_tag_i(fpu_tag_in),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready), .drain_i(drain),
    .flush_i(flush), .drained_o(drained), .busy_o(busy)
  );

  fpnew_req_scheduler #(.NumReq(N), .Width(64), .MaxOutstanding(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_i(req),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_o(b_rsp), .fpu_req_o(b_fpu_req),
    .fpu_in_valid_o(b_in_valid), .fpu_in_ready_i(b_in_ready), .fpu_tag_o(b_tag),
    .fpu_flush_o(b_flush_o), .fpu_rsp_i(b_fpu_rsp), .fpu_tag_i(b_tag_in),
    .fpu_out_valid_i(b_out_valid), .fpu_out_ready_o(b_out_ready), .drain_i(b_drain),
    .flush_i(b_flush), .drained_o(b_drained), .busy_o(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic fpu_req_t mk_req(input int i);
    fpu_req_t r;
    r             = '0;
    r.operands[0] = 64'hA5A5_0000_0000_0000 | 64'(i);
    r.operands[1] = 64'(i * 3 + 7);
    r.op          = 4'(i + 1);
    return r;
  endfunction

  function automatic fpu_rsp_t mk_rsp(input int t);
    fpu_rsp_t r;
    r.result = 64'hF00D_0000_0000_0100 + 64'(t);
    r.status = status_t'(5'(t + 1));
    return r;
  endfunction

  task automatic idle_all();
    req_valid = '0; fpu_in_ready = 1'b0; rsp_ready = '1; fpu_out_valid = 1'b0;
    fpu_tag_in = '0; fpu_rsp = '0; drain = 1'b0; flush = 1'b0;
    b_req_valid = '0; b_in_ready = 1'b0; b_rsp_ready = '1; b_out_valid = 1'b0;
    b_tag_in = '0; b_fpu_rsp = '0; b_drain = 1'b0; b_flush = 1'b0;
  endtask

  // Reset with live requests present; no valid/ready output may assert.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; idle_all();
    req_valid = '1; fpu_in_ready = 1'b1; b_req_valid = '1; b_in_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_in_valid", fpu_in_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_ready", fpu_out_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flush", fpu_flush, 0);
    chk("rst_drained", drained, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_in_valid", b_in_valid, 0);
    @(negedge clk);
    rst = 1'b0; idle_all();
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ir;
    logic [3:0] rdy;
    logic       iv;
    logic [1:0] tag;
    logic       busy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    idle_all();
    for (int i = 0; i < int'(N); i++) req[i] = mk_req(i);

    // Round-robin issue: wrap, skip, lock on stalled winner, cap at 8.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[9]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};

    do_reset();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req_valid = tbl[k].valid; fpu_in_ready = tbl[k].ir;
      #1;
      chk($sformatf("rr_ready[%0d]", k), req_ready, tbl[k].rdy);
      chk($sformatf("rr_in_valid[%0d]", k), fpu_in_valid, tbl[k].iv);
      chk($sformatf("rr_busy[%0d]", k), busy, tbl[k].busy);
      if (tbl[k].iv) begin
        chk($sformatf("rr_tag[%0d]", k), fpu_tag, tbl[k].tag);
        chk($sformatf("rr_req[%0d]", k), fpu_req.operands[0], mk_req(int'(tbl[k].tag)).operands[0]);
      end
    end

    // Response backpressure and back-to-back refill.
    do_reset();
    repeat (3) begin
      @(negedge clk); req_valid = '1; fpu_in_ready = 1'b1;
    end
    @(negedge clk);
    req_valid = '0; fpu_in_ready = 1'b0;
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd2; fpu_rsp = mk_rsp(2); rsp_ready = 4'b1011;
    #1; chk("rsp_out_ready_empty", fpu_out_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); fpu_tag_in = 2'd1; fpu_rsp = mk_rsp(1);
      #1;
      chk($sformatf("rsp_hold_valid[%0d]", k), rsp_valid, 4'b0100);
      chk($sformatf("rsp_hold_data[%0d]", k), rsp.result, mk_rsp(2).result);
      chk($sformatf("rsp_backpressure[%0d]", k), fpu_out_ready, 0);
    end
    @(negedge clk); rsp_ready = 4'b1111;
    #1; chk("rsp_release_valid", rsp_valid, 4'b0100); chk("rsp_refill_ready", fpu_out_ready, 1);
    @(negedge clk); fpu_tag_in = 2'd3; fpu_rsp = mk_rsp(3);
    #1; chk("rsp_b2b_valid1", rsp_valid, 4'b0010); chk("rsp_b2b_data1", rsp.result, mk_rsp(1).result);
    chk("rsp_b2b_ready", fpu_out_ready, 1);
    @(negedge clk); fpu_out_valid = 1'b0;
    #1; chk("rsp_b2b_valid3", rsp_valid, 4'b1000); chk("rsp_b2b_data3", rsp.result, mk_rsp(3).result);
    chk("rsp_b2b_status3", rsp.status, mk_rsp(3).status);
    @(negedge clk); #1;
    chk("rsp_empty_valid", rsp_valid, 0); chk("rsp_empty_busy", busy, 0);

    // Drain with three in flight.
    do_reset();
    repeat (3) begin
      @(negedge clk); req_valid = '1; fpu_in_ready = 1'b1;
    end
    @(negedge clk); req_valid = '0; drain = 1'b1;
    #1; chk("drain_enter_drained", drained, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = '1; fpu_out_valid = 1'b1; fpu_tag_in = IW'(k); fpu_rsp = mk_rsp(k);
      #1;
      chk($sformatf("drain_no_issue[%0d]", k), fpu_in_valid, 0);
      chk($sformatf("drain_no_ready[%0d]", k), req_ready, 0);
      chk($sformatf("drain_not_done[%0d]", k), drained, 0);
    end
    @(negedge clk); fpu_out_valid = 1'b0;
    #1; chk("drain_last_pending", drained, 0); chk("drain_last_rsp", rsp_valid, 4'b0100);
    @(negedge clk); #1;
    chk("drain_done", drained, 1); chk("drain_busy", busy, 0); chk("drain_still_idle", fpu_in_valid, 0);
    @(negedge clk); drain = 1'b0;
    #1; chk("drain_exit_lag", fpu_in_valid, 0);
    @(negedge clk); fpu_in_ready = 1'b0;
    #1; chk("drain_resume_valid", fpu_in_valid, 1); chk("drain_resume_tag", fpu_tag, 2'd3);
    chk("drain_resume_drained", drained, 0);

    // Flush with five in flight and a held response.
    do_reset();
    repeat (6) begin
      @(negedge clk); req_valid = '1; fpu_in_ready = 1'b1;
    end
    @(negedge clk);
    req_valid = '0; fpu_in_ready = 1'b0;
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd3; fpu_rsp = mk_rsp(3); rsp_ready = '0;
    #1; chk("flush_pre_out_ready", fpu_out_ready, 1);
    @(negedge clk); fpu_out_valid = 1'b0; flush = 1'b1;
    #1; chk("flush_req_cycle", fpu_flush, 0); chk("flush_pre_busy", busy, 1);
    chk("flush_pre_rsp", rsp_valid, 4'b1000);
    @(negedge clk);
    flush = 1'b0; req_valid = '1; fpu_in_ready = 1'b1; fpu_out_valid = 1'b1; fpu_tag_in = 2'd0;
    #1; chk("flush_pulse", fpu_flush, 1); chk("flush_in_valid", fpu_in_valid, 0);
    chk("flush_req_ready", req_ready, 0); chk("flush_out_ready", fpu_out_ready, 0);
    @(negedge clk); fpu_out_valid = 1'b0; fpu_in_ready = 1'b0;
    #1; chk("flush_end", fpu_flush, 0); chk("flush_busy", busy, 0);
    chk("flush_rsp_cleared", rsp_valid, 0); chk("flush_resume_valid", fpu_in_valid, 1);
    chk("flush_ptr_kept", fpu_tag, 2'd2);

    // Outstanding cap of 2, then simultaneous issue and return.
    do_reset();
    @(negedge clk); b_req_valid = '1; b_in_ready = 1'b1;
    #1; chk("cap_issue0_valid", b_in_valid, 1); chk("cap_issue0_tag", b_tag, 2'd0);
    @(negedge clk);
    #1; chk("cap_issue1_valid", b_in_valid, 1); chk("cap_issue1_tag", b_tag, 2'd1);
    @(negedge clk);
    #1; chk("cap_full_valid", b_in_valid, 0); chk("cap_full_ready", b_req_ready, 0);
    @(negedge clk);
    #1; chk("cap_full_valid2", b_in_valid, 0);
    @(negedge clk); b_out_valid = 1'b1; b_tag_in = 2'd0; b_fpu_rsp = mk_rsp(0);
    #1; chk("cap_return_no_issue", b_in_valid, 0); chk("cap_return_ready", b_out_ready, 1);
    @(negedge clk); b_tag_in = 2'd1; b_fpu_rsp = mk_rsp(1);
    #1; chk("cap_same_cycle_valid", b_in_valid, 1); chk("cap_same_cycle_tag", b_tag, 2'd2);
    chk("cap_same_cycle_ready", b_req_ready, 4'b0100);
    @(negedge clk); b_out_valid = 1'b0;
    #1; chk("cap_after_same_valid", b_in_valid, 1); chk("cap_after_same_tag", b_tag, 2'd3);
    @(negedge clk);
    #1; chk("cap_refull_valid", b_in_valid, 0); chk("cap_refull_busy", b_busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
